sipo_buffer: RTL and testbench

Serial-in, parallel-out word buffer. It accepts WIDTH-bit words over a valid/ready handshake and assembles them into one DEPTH*WIDTH-bit block, which it presents on a second valid/ready handshake. It sits on the absorb side of the SHAKE datapath, packing bus words into rate-sized blocks for the permutation core. It is the input-side counterpart of the existing parallel-in serial-out output buffer and uses the same word-order convention: word 0 occupies the most significant slice.

---
 rtl/sipo_buffer.sv | 178 +++++++++++++++++
 tb/tb_sipo_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_buffer.sv
// ============================================================================
// Module   : sipo_buffer
// Purpose  : Serial-in, parallel-out word buffer. It packs WIDTH-bit words,
//            received over a valid/ready handshake, into one DEPTH*WIDTH-bit
//            block, then presents the block on a second valid/ready handshake.
//            Word 0 occupies the most significant slice of the block.
// Revision : 1.0 - initial release
//
// Parameters
//   WIDTH      word width in bits (default 64)
//   DEPTH      words per block (default 17, one SHAKE256 rate block)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush of the partial or held block (highest priority)
//   in_valid   input word valid
//   in_ready   buffer can accept a word (high in FILL)
//   in_data    input word
//   in_last    final word of the message (SIPO_BUFFER_LAST_EN builds only)
//   out_valid  assembled block held and valid (high in HOLD)
//   out_ready  consumer takes the block
//   out_data   assembled block
//   out_count  number of words written into the current block
//   out_last   held block ends the message (SIPO_BUFFER_LAST_EN builds only)
//
// Configuration macro
//   SIPO_BUFFER_LAST_EN  when defined, adds in_last/out_last and allows a
//                        block to close early on a word flagged in_last.
// ============================================================================
`default_nettype none

module sipo_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 17
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
`ifdef SIPO_BUFFER_LAST_EN
  input  logic                        in_last,
  output logic                        out_last,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH*WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0]  out_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = DEPTH * WIDTH;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   data_q,  data_d;

  // Early-termination flag of the accepted word; constant 0 when the
  // message-boundary feature is not built.
  logic            w_word_last;
`ifdef SIPO_BUFFER_LAST_EN
  logic            last_q, last_d;
  assign w_word_last = in_last;
`else
  assign w_word_last = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
`ifdef SIPO_BUFFER_LAST_EN
    last_d  = last_q;
`endif

    if (clear) begin
      // Flush wins over any word or handoff presented in the same cycle.
      state_d = FILL;
      count_d = '0;
      data_d  = '0;
`ifdef SIPO_BUFFER_LAST_EN
      last_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        FILL: begin
          // in_ready is 1 throughout FILL, so in_valid alone accepts a word.
          if (in_valid) begin
            // Word k lands in slice DEPTH-1-k so word 0 is most significant.
            for (int k = 0; k < int'(DEPTH); k++) begin
              if (count_q == CW'(k)) begin
                data_d[(int'(DEPTH) - k) * int'(WIDTH) - 1 -: WIDTH] = in_data;
              end
            end
            count_d = count_q + CW'(1);
            if ((count_q == CW'(DEPTH - 1)) || w_word_last) begin
              state_d = HOLD;
`ifdef SIPO_BUFFER_LAST_EN
              last_d  = in_last;
`endif
            end
          end
        end

        HOLD: begin
          // Block is frozen until the consumer takes it; then start clean
          // so unwritten slots of the next block read as zero.
          if (out_ready) begin
            state_d = FILL;
            count_d = '0;
            data_d  = '0;
`ifdef SIPO_BUFFER_LAST_EN
            last_d  = 1'b0;
`endif
          end
        end

        default: begin
          state_d = FILL;
          count_d = '0;
          data_d  = '0;
`ifdef SIPO_BUFFER_LAST_EN
          last_d  = 1'b0;
`endif
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

`ifdef SIPO_BUFFER_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign out_last = last_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so out_ready never reaches
  // in_ready combinationally.
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_buffer.sv
// ============================================================================
// Module   : tb_sipo_buffer
// Purpose  : Directed self-checking bench for sipo_buffer (WIDTH=8, DEPTH=4).
//            Early-termination checks are built when SIPO_BUFFER_LAST_EN is
//            defined; otherwise the short-stream check for the plain build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_buffer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [D*W-1:0]  out_data;
  logic [CW-1:0]   out_count;
`ifdef SIPO_BUFFER_LAST_EN
  logic            in_last;
  logic            out_last;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_buffer #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SIPO_BUFFER_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

`ifdef SIPO_BUFFER_LAST_EN
  task automatic push_last(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask
`endif

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_hold(input string tag, input logic [D*W-1:0] data, input logic [CW-1:0] cnt);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_ready"}, 64'(in_ready),  64'd0);
    chk({tag, "_data"},  64'(out_data),  64'(data));
    chk({tag, "_count"}, 64'(out_count), 64'(cnt));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready),  64'd1);
    chk({tag, "_data"},  64'(out_data),  64'd0);
    chk({tag, "_count"}, 64'(out_count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vpat;
    int         idx;

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef SIPO_BUFFER_LAST_EN
    in_last   = 1'b0;
`endif
    #12;
    chk_empty("reset");
`ifdef SIPO_BUFFER_LAST_EN
    chk("reset_last", 64'(out_last), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // ---- Full block, then held under backpressure ----
    push(8'hA1);
    push(8'hA2);
    chk("fill_partial_data",  64'(out_data),  64'hA1A20000);
    chk("fill_partial_count", 64'(out_count), 64'd2);
    chk("fill_partial_valid", 64'(out_valid), 64'd0);
    push(8'hA3);
    push(8'hA4);
    chk_hold("full", 32'hA1A2A3A4, 3'd4);
    repeat (5) tick();
    chk_hold("held5", 32'hA1A2A3A4, 3'd4);

    // ---- Handoff, then next block ----
    handoff();
    chk_empty("after_handoff");
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk_hold("second", 32'h11223344, 3'd4);
    handoff();

    // ---- Input backpressure: garbage data while in_valid is low ----
    vpat = 8'b1011_0101;   // bit i = in_valid in cycle i
    idx  = 0;
    for (int c = 0; c < 8 && idx < 4; c++) begin
      in_valid = vpat[c];
      in_data  = vpat[c] ? 8'(idx + 1) : 8'hEE;
      tick();
      if (vpat[c]) idx++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk_hold("bp", 32'h01020304, 3'd4);
    // Words offered during HOLD must be ignored.
    push(8'h55);
    push(8'h66);
    chk_hold("bp_hold_pulse", 32'h01020304, 3'd4);
    handoff();

    // ---- Clear with a simultaneous word ----
    push(8'hC1);
    push(8'hC2);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk_empty("clear");
    push(8'hD1);
    push(8'hD2);
    push(8'hD3);
    push(8'hD4);
    chk_hold("after_clear", 32'hD1D2D3D4, 3'd4);

    // Clear also drops a held block, overriding out_ready=0.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_empty("clear_hold");

    // ---- Asynchronous reset mid-block, between clock edges ----
    push(8'hE1);
    push(8'hE2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_empty("async_rst_mid");
    rst_n = 1'b1;
    tick();
    push(8'hF1);
    push(8'hF2);
    push(8'hF3);
    push(8'hF4);
    chk_hold("after_rst", 32'hF1F2F3F4, 3'd4);
    // Reset while holding: block disappears immediately.
    #2;
    rst_n = 1'b0;
    #1;
    chk_empty("async_rst_hold");
    rst_n = 1'b1;
    tick();

`ifdef SIPO_BUFFER_LAST_EN
    // ---- Partial block closed by in_last ----
    push(8'hB1);
    push_last(8'hB2);
    chk_hold("partial", 32'hB1B20000, 3'd2);
    chk("partial_last", 64'(out_last), 64'd1);
    handoff();
    chk("partial_last_clr", 64'(out_last), 64'd0);
    chk_empty("partial_handoff");

    // in_last on the first word.
    push_last(8'h77);
    chk_hold("first_last", 32'h77000000, 3'd1);
    chk("first_last_flag", 64'(out_last), 64'd1);
    handoff();

    // in_last without in_valid is ignored.
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    chk_empty("last_no_valid");

    // in_last on the final word of a full block.
    push(8'h91);
    push(8'h92);
    push(8'h93);
    push_last(8'h94);
    chk_hold("full_last", 32'h91929394, 3'd4);
    chk("full_last_flag", 64'(out_last), 64'd1);
    // in_last during HOLD changes nothing.
    push_last(8'h99);
    chk_hold("last_in_hold", 32'h91929394, 3'd4);
    handoff();
    chk("full_last_clr", 64'(out_last), 64'd0);
`else
    // ---- Three-word stream never closes a block ----
    push(8'h31);
    push(8'h32);
    push(8'h33);
    repeat (3) tick();
    chk("short_valid", 64'(out_valid), 64'd0);
    chk("short_count", 64'(out_count), 64'd3);
    chk("short_data",  64'(out_data),  64'h31323300);
    push(8'h34);
    chk_hold("short_done", 32'h31323334, 3'd4);
    handoff();
    chk_empty("short_handoff");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
